// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants and receiver state encoding
package i2s_pkg;
   localparam int DATA_W_DEFAULT = 24;

   // Channel encoding on ws, shared with the transmitter.
   localparam logic WS_LEFT = 1'b0;

   typedef enum logic [1:0] {
      ALIGN,
      LEFT,
      RIGHT
   } state_t;
endpackage

// File: rtl/i2s_receiver_if.sv
// rtl/i2s_receiver_if.sv - left/right sample pair handshake towards the DSP chain
interface i2s_receiver_if
   import i2s_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
);
   logic [DATA_W-1:0] audio_left;
   logic [DATA_W-1:0] audio_right;
   logic              out_valid;
   logic              out_ready;

   modport master (output audio_left, output audio_right, output out_valid, input out_ready);
   modport slave  (input audio_left, input audio_right, input out_valid, output out_ready);
endinterface

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - N-stage synchroniser with registered rising-edge pulse
module i2s_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);
   logic [STAGES-1:0] sync_sr;
   logic              last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_sr <= '0;
         last    <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync_sr <= {sync_sr[STAGES-2:0], d};
         last    <= sync_sr[STAGES-1];
         rise    <= sync_sr[STAGES-1] & ~last;
      end
   end
endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - oversampling Philips I2S capture into 24-bit left/right pairs
module i2s_receiver
   import i2s_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           i2s_clk,
   input  logic           i2s_ws,
   input  logic           i2s_data,
   i2s_receiver_if.master pair_if,
   output logic           locked,
   output logic           frame_err,
   output logic           overrun
);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W);
   localparam logic [CW-1:0] TOP_IDX = CW'(DATA_W - 1);

   logic                   bev;
   logic [SYNC_STAGES-1:0] ws_sr;
   logic [SYNC_STAGES-1:0] data_sr;
   logic                   ws_s;
   logic                   data_s;
   logic                   ws_prev;
   logic                   boundary;
   logic                   short_word;
   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [DATA_W-1:0]      word;
   logic [DATA_W-1:0]      word_next;
   logic [DATA_W-1:0]      left_hold;
   logic [DATA_W-1:0]      audio_left_r;
   logic [DATA_W-1:0]      audio_right_r;
   logic                   out_valid_r;

   i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
      .clk   (clk),
      .reset (reset),
      .d     (i2s_clk),
      .rise  (bev)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws_sr   <= '0;
         data_sr <= '0;
      end else begin
         ws_sr   <= {ws_sr[SYNC_STAGES-2:0], i2s_ws};
         data_sr <= {data_sr[SYNC_STAGES-2:0], i2s_data};
      end
   end

   assign ws_s       = ws_sr[SYNC_STAGES-1];
   assign data_s     = data_sr[SYNC_STAGES-1];
   assign boundary   = (ws_s != ws_prev);
   // The boundary bit itself counts towards the closing word.
   assign short_word = (cnt < TOP_IDX);

   always_comb begin
      word_next = word;
      if (cnt < CNT_MAX) begin
         word_next[TOP_IDX - cnt] = data_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ALIGN;
         ws_prev       <= 1'b0;
         cnt           <= '0;
         word          <= '0;
         left_hold     <= '0;
         audio_left_r  <= '0;
         audio_right_r <= '0;
         out_valid_r   <= 1'b0;
         locked        <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (out_valid_r && pair_if.out_ready) begin
            out_valid_r <= 1'b0;
         end
         if (bev) begin
            ws_prev <= ws_s;
            if (boundary) begin
               cnt  <= '0;
               word <= '0;
            end else if (cnt < CNT_MAX) begin
               cnt  <= cnt + 1'b1;
               word <= word_next;
            end
            case (state)
               ALIGN: begin
                  if (boundary && ws_s == WS_LEFT) begin
                     state  <= LEFT;
                     locked <= 1'b1;
                  end
               end
               LEFT: begin
                  if (boundary) begin
                     left_hold <= word_next;
                     frame_err <= short_word;
                     state     <= RIGHT;
                  end
               end
               RIGHT: begin
                  if (boundary) begin
                     frame_err <= short_word;
                     state     <= LEFT;
                     if (!out_valid_r || pair_if.out_ready) begin
                        audio_left_r  <= left_hold;
                        audio_right_r <= word_next;
                        out_valid_r   <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end
               default: state <= ALIGN;
            endcase
         end
      end
   end

   assign pair_if.audio_left  = audio_left_r;
   assign pair_if.audio_right = audio_right_r;
   assign pair_if.out_valid   = out_valid_r;
endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - scoreboard bench for i2s_receiver at clk = 8x bclk
`timescale 1ns/1ps
module tb_i2s_receiver;
   logic clk = 1'b0;
   logic reset;
   logic i2s_clk;
   logic i2s_ws;
   logic i2s_data;
   logic locked;
   logic frame_err;
   logic overrun;

   i2s_receiver_if #(.DATA_W(24)) pif ();

   i2s_receiver #(.DATA_W(24), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .i2s_clk   (i2s_clk),
      .i2s_ws    (i2s_ws),
      .i2s_data  (i2s_data),
      .pair_if   (pif),
      .locked    (locked),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [47:0] exp_q[$];
   time         lat_q[$];
   time         t_exp;
   logic [47:0] pair_exp;
   int          ferr_cnt = 0;
   int          ovr_cnt = 0;
   logic        prev_valid;
   logic        pend;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted pair, checks latency of marked closes.
   initial begin
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            if (frame_err === 1'b1) ferr_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (pif.out_valid === 1'b1 && !prev_valid && lat_q.size() > 0) begin
               t_exp = lat_q.pop_front();
               check("latency_time", 64'($time), 64'(t_exp));
            end
            if (pif.out_valid === 1'b1 && pif.out_ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pair: got %h/%h expected none", pif.audio_left, pif.audio_right);
               end else begin
                  pair_exp = exp_q.pop_front();
                  check("pair_data", {16'h0, pif.audio_left, pif.audio_right}, {16'h0, pair_exp});
               end
            end
            prev_valid = (pif.out_valid === 1'b1);
         end
      end
   end

   task automatic bclk_cycle(input logic ws, input logic d, input logic mark);
      i2s_clk  = 1'b0;
      i2s_ws   = ws;
      i2s_data = d;
      repeat (4) @(posedge clk);
      #1;
      i2s_clk = 1'b1;
      if (mark) lat_q.push_back($time + 44);
      repeat (4) @(posedge clk);
      #1;
   endtask

   // First bclk carries the previous word's LSB slot; this word's last bit is left pending.
   task automatic send_word(input logic ws, input logic [31:0] bits, input int n, input logic mark);
      bclk_cycle(ws, pend, mark);
      for (int i = 1; i < n; i++) bclk_cycle(ws, bits[32-i], 1'b0);
      pend = bits[32-n];
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic mark);
      send_word(1'b0, {l, 8'h00}, 32, mark);
      send_word(1'b1, {r, 8'h00}, 32, 1'b0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      i2s_clk  = 1'b0;
      i2s_ws   = 1'b0;
      i2s_data = 1'b0;
      pend     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      ferr_cnt = 0;
      ovr_cnt  = 0;
   endtask

   function automatic logic [63:0] all_outputs();
      return {12'h0, pif.audio_left, pif.audio_right, pif.out_valid, locked, frame_err, overrun};
   endfunction

   initial begin
      reset         = 1'b1;
      i2s_clk       = 1'b0;
      i2s_ws        = 1'b0;
      i2s_data      = 1'b0;
      pend          = 1'b0;
      pif.out_ready = 1'b1;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      check("outputs_in_reset", all_outputs(), 64'h0);
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("outputs_idle", all_outputs(), 64'h0);

      // Alignment from mid-right-word
      send_word(1'b1, 32'hDEADBEEF, 20, 1'b0);
      check("locked_before_align", 64'(locked), 64'h0);
      exp_q.push_back({24'h123456, 24'hABCDEF});
      send_frame(24'h123456, 24'hABCDEF, 1'b0);
      check("locked_after_align", 64'(locked), 64'h1);
      send_word(1'b0, 32'h0, 32, 1'b0);
      check("align_drained", 64'(exp_q.size()), 64'h0);
      check("align_frame_err", 64'(ferr_cnt), 64'h0);

      // Latency, back-to-back frames with out_ready high
      do_reset();
      send_word(1'b1, 32'h0F0F0F0F, 32, 1'b0);
      exp_q.push_back({24'h111111, 24'h222222});
      exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
      exp_q.push_back({24'hFFFFFF, 24'h000000});
      exp_q.push_back({24'h7FFFFF, 24'h800001});
      send_frame(24'h111111, 24'h222222, 1'b0);
      send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1);
      send_frame(24'hFFFFFF, 24'h000000, 1'b1);
      send_frame(24'h7FFFFF, 24'h800001, 1'b1);
      send_word(1'b0, 32'h0, 32, 1'b1);
      check("b2b_drained", 64'(exp_q.size()), 64'h0);
      check("b2b_latency_drained", 64'(lat_q.size()), 64'h0);
      check("b2b_overrun", 64'(ovr_cnt), 64'h0);
      check("b2b_frame_err", 64'(ferr_cnt), 64'h0);

      // Backpressure over two frames
      do_reset();
      pif.out_ready = 1'b0;
      send_word(1'b1, 32'h0, 32, 1'b0);
      exp_q.push_back({24'h000001, 24'h800000});
      send_frame(24'h000001, 24'h800000, 1'b0);
      send_frame(24'hCAFE00, 24'h00BEEF, 1'b0);
      send_word(1'b0, 32'h0, 32, 1'b0);
      check("bp_overrun_once", 64'(ovr_cnt), 64'h1);
      check("bp_held_pair", {15'h0, pif.audio_left, pif.audio_right, pif.out_valid}, {15'h0, 24'h000001, 24'h800000, 1'b1});
      pif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("bp_drained", 64'(exp_q.size()), 64'h0);
      check("bp_valid_cleared", 64'(pif.out_valid), 64'h0);

      // Short 16-bit left word
      do_reset();
      send_word(1'b1, 32'h0, 32, 1'b0);
      exp_q.push_back({24'hBEEF00, 24'h654321});
      send_word(1'b0, {16'hBEEF, 16'h0000}, 16, 1'b0);
      send_word(1'b1, {24'h654321, 8'h00}, 32, 1'b0);
      send_word(1'b0, 32'h0, 32, 1'b0);
      check("short_drained", 64'(exp_q.size()), 64'h0);
      check("short_frame_err_once", 64'(ferr_cnt), 64'h1);

      // Reset halfway through a right word
      do_reset();
      send_word(1'b1, 32'h0, 32, 1'b0);
      exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
      send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0);
      send_word(1'b0, {24'h333333, 8'h00}, 32, 1'b0);
      send_word(1'b1, {24'h444444, 8'h00}, 16, 1'b0);
      check("pre_reset_drained", 64'(exp_q.size()), 64'h0);
      check("pre_reset_left", 64'(pif.audio_left), 64'h0F0F0F);
      reset = 1'b1;
      #1;
      check("outputs_mid_reset", all_outputs(), 64'h0);
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      ferr_cnt = 0;
      ovr_cnt  = 0;
      send_word(1'b1, {24'h444444, 8'h00}, 16, 1'b0);
      exp_q.push_back({24'h5A5A5A, 24'hA5A5A5});
      send_frame(24'h5A5A5A, 24'hA5A5A5, 1'b0);
      send_word(1'b0, 32'h0, 32, 1'b0);
      check("post_reset_drained", 64'(exp_q.size()), 64'h0);
      check("post_reset_locked", 64'(locked), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
